// File: rtl/bmlp_sched_pkg.sv
// Shared types and defaults for the binary-MLP layer scheduler.
package bmlp_sched_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    LEND,
    DONE
  } state_t;

endpackage

// File: rtl/bmlp_step_counter.sv
// Clearable step counter: counts 0..end_count on en, wrapping to 0 after end_count.
module bmlp_step_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] end_count,
  output logic [CNT_W-1:0] cur_count,
  output logic             fin
);

  assign fin = (cur_count == end_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_count <= '0;
    end else if (clr) begin
      cur_count <= '0;
    end else if (en) begin
      cur_count <= fin ? '0 : cur_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bmlp_layer_sched.sv
// Layer/neuron/word sequencer for the XNOR-popcount MAC datapath, with pipeline
// drain and ping-pong buffer swap between layers.
module bmlp_layer_sched
  import bmlp_sched_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LAYER_W  = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] cfg_last_layer,
  input  logic [CNT_W-1:0]   cfg_in_words,
  input  logic [CNT_W-1:0]   cfg_out_neurons,
  input  logic               dp_ready,
  output logic               busy,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [CNT_W-1:0]   neuron_idx,
  output logic [CNT_W-1:0]   word_idx,
  output logic               mac_en,
  output logic               acc_clr,
  output logic               neuron_done,
  output logic               layer_done,
  output logic               buf_swap,
  output logic               done
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] in_words_q;
  logic [CNT_W-1:0] out_neurons_q;
  logic [CNT_W-1:0] word_end;
  logic [CNT_W-1:0] neuron_end;
  logic [DW-1:0]    drain_cnt;
  logic             transfer;
  logic             word_fin;
  logic             neuron_fin;
  logic             cnt_clr;

  assign word_end    = in_words_q - CNT_W'(1);
  assign neuron_end  = out_neurons_q - CNT_W'(1);
  assign transfer    = mac_en & dp_ready;
  assign cnt_clr     = (state != RUN);
  assign acc_clr     = mac_en & (word_idx == '0);
  assign neuron_done = mac_en & word_fin;

  bmlp_step_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (transfer),
    .end_count (word_end),
    .cur_count (word_idx),
    .fin       (word_fin)
  );

  bmlp_step_counter #(.CNT_W(CNT_W)) u_neuron_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (transfer & word_fin),
    .end_count (neuron_end),
    .cur_count (neuron_idx),
    .fin       (neuron_fin)
  );

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start) nxt = LOAD;
        LOAD:  nxt = (cfg_in_words == '0 || cfg_out_neurons == '0) ? LEND : RUN;
        RUN:   if (transfer && word_fin && neuron_fin) nxt = DRAIN;
        DRAIN: if (drain_cnt == DW'(PIPE_LAT - 1)) nxt = LEND;
        LEND:  nxt = (layer_idx == cfg_last_layer) ? DONE : LOAD;
        DONE:  nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      mac_en        <= 1'b0;
      layer_done    <= 1'b0;
      buf_swap      <= 1'b0;
      done          <= 1'b0;
      layer_idx     <= '0;
      in_words_q    <= '0;
      out_neurons_q <= '0;
      drain_cnt     <= '0;
    end else begin
      state      <= nxt;
      busy       <= (nxt != IDLE);
      mac_en     <= (nxt == RUN);
      layer_done <= (nxt == LEND);
      buf_swap   <= (nxt == LEND);
      done       <= (nxt == DONE);
      drain_cnt  <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
      if (state == LOAD) begin
        in_words_q    <= cfg_in_words;
        out_neurons_q <= cfg_out_neurons;
      end
      if (nxt == IDLE) begin
        layer_idx <= '0;
      end else if (state == LEND && nxt == LOAD) begin
        layer_idx <= layer_idx + LAYER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bmlp_layer_sched.sv
// Randomized bench for bmlp_layer_sched against a cycle-table reference model
// derived from per-layer configs and a per-cycle dp_ready pattern.
module tb_bmlp_layer_sched;

  localparam int CNT_W    = 16;
  localparam int LAYER_W  = 2;
  localparam int PIPE_LAT = 2;
  localparam int MAXC     = 1024;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [LAYER_W-1:0] cfg_last_layer;
  logic [CNT_W-1:0]   cfg_in_words;
  logic [CNT_W-1:0]   cfg_out_neurons;
  logic               dp_ready;
  logic               busy;
  logic [LAYER_W-1:0] layer_idx;
  logic [CNT_W-1:0]   neuron_idx;
  logic [CNT_W-1:0]   word_idx;
  logic               mac_en;
  logic               acc_clr;
  logic               neuron_done;
  logic               layer_done;
  logic               buf_swap;
  logic               done;

  typedef struct packed {
    logic               busy;
    logic               mac;
    logic               clr;
    logic               nd;
    logic               ld;
    logic               dn;
    logic [LAYER_W-1:0] lay;
    logic [CNT_W-1:0]   neu;
    logic [CNT_W-1:0]   wrd;
  } exp_t;

  logic [CNT_W-1:0] in_tbl  [4];
  logic [CNT_W-1:0] out_tbl [4];
  logic             ready   [MAXC];
  exp_t             ex      [MAXC];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bmlp_layer_sched #(
    .CNT_W    (CNT_W),
    .LAYER_W  (LAYER_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .cfg_last_layer  (cfg_last_layer),
    .cfg_in_words    (cfg_in_words),
    .cfg_out_neurons (cfg_out_neurons),
    .dp_ready        (dp_ready),
    .busy            (busy),
    .layer_idx       (layer_idx),
    .neuron_idx      (neuron_idx),
    .word_idx        (word_idx),
    .mac_en          (mac_en),
    .acc_clr         (acc_clr),
    .neuron_done     (neuron_done),
    .layer_done      (layer_done),
    .buf_swap        (buf_swap),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External per-layer config table, indexed by the current layer.
  always_comb begin
    cfg_in_words    = in_tbl[layer_idx];
    cfg_out_neurons = out_tbl[layer_idx];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready_all();
    for (int i = 0; i < MAXC; i++) ready[i] = 1'b1;
  endtask

  // Builds the expected cycle table from the configs, then drives a run starting at cycle 0.
  task automatic run_check(input int start2);
    int t;
    int t_end;
    for (int i = 0; i < MAXC; i++) ex[i] = '0;
    t = 1;
    for (int l = 0; l <= int'(cfg_last_layer); l++) begin
      ex[t].busy = 1'b1;
      ex[t].lay  = LAYER_W'(l);
      t++;
      if (in_tbl[l] != 0 && out_tbl[l] != 0) begin
        for (int unsigned n = 0; n < out_tbl[l]; n++) begin
          for (int unsigned w = 0; w < in_tbl[l]; w++) begin
            do begin
              ex[t].busy = 1'b1;
              ex[t].mac  = 1'b1;
              ex[t].lay  = LAYER_W'(l);
              ex[t].neu  = CNT_W'(n);
              ex[t].wrd  = CNT_W'(w);
              ex[t].clr  = (w == 0);
              ex[t].nd   = (w == in_tbl[l] - 1);
              t++;
            end while (!ready[t-1] && t < MAXC - 16);
          end
        end
        for (int d = 0; d < PIPE_LAT; d++) begin
          ex[t].busy = 1'b1;
          ex[t].lay  = LAYER_W'(l);
          t++;
        end
      end
      ex[t].busy = 1'b1;
      ex[t].ld   = 1'b1;
      ex[t].lay  = LAYER_W'(l);
      t++;
    end
    ex[t].busy = 1'b1;
    ex[t].dn   = 1'b1;
    ex[t].lay  = cfg_last_layer;
    t++;
    t_end = t;

    for (int c = 0; c <= t_end; c++) begin
      start    = (c == 0) || (c == start2 && c > 0 && c < t_end);
      dp_ready = ready[c];
      @(negedge clk);
      check("busy", 32'(busy), 32'(ex[c].busy));
      check("mac_en", 32'(mac_en), 32'(ex[c].mac));
      check("layer_done", 32'(layer_done), 32'(ex[c].ld));
      check("buf_swap", 32'(buf_swap), 32'(ex[c].ld));
      check("done", 32'(done), 32'(ex[c].dn));
      if (ex[c].busy) check("layer_idx", 32'(layer_idx), 32'(ex[c].lay));
      if (ex[c].mac) begin
        check("word_idx", 32'(word_idx), 32'(ex[c].wrd));
        check("neuron_idx", 32'(neuron_idx), 32'(ex[c].neu));
        check("acc_clr", 32'(acc_clr), 32'(ex[c].clr));
        check("neuron_done", 32'(neuron_done), 32'(ex[c].nd));
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic cfg_test1();
    cfg_last_layer = '0;
    in_tbl[0]  = 16'd3;
    out_tbl[0] = 16'd2;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; dp_ready = 1'b0; cfg_last_layer = '0;
    for (int i = 0; i < 4; i++) begin
      in_tbl[i]  = '0;
      out_tbl[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_mac_en", 32'(mac_en), 0);
    check("rst_layer_idx", 32'(layer_idx), 0);
    check("rst_word_idx", 32'(word_idx), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    next_cyc();

    // Test 1: single layer, 3 words x 2 neurons, always ready
    cfg_test1();
    set_ready_all();
    run_check(-1);

    // Test 2: stall at cycles 3..5
    for (int i = 3; i <= 5; i++) ready[i] = 1'b0;
    run_check(-1);

    // Test 3: three layers
    set_ready_all();
    cfg_last_layer = 2'd2;
    in_tbl[0] = 16'd4; out_tbl[0] = 16'd2;
    in_tbl[1] = 16'd2; out_tbl[1] = 16'd3;
    in_tbl[2] = 16'd3; out_tbl[2] = 16'd1;
    run_check(-1);

    // Test 4: middle layer has no neurons
    out_tbl[1] = 16'd0;
    run_check(-1);

    // Test 5a: abort on the third RUN beat
    cfg_test1();
    set_ready_all();
    dp_ready = 1'b1;
    start = 1'b1;
    next_cyc();
    start = 1'b0;
    repeat (3) next_cyc();
    @(negedge clk);
    check("abort_pre_mac", 32'(mac_en), 1);
    check("abort_pre_word", 32'(word_idx), 2);
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_mac_en", 32'(mac_en), 0);
    for (int i = 0; i < 8; i++) begin
      check("abort_layer_done", 32'(layer_done), 0);
      check("abort_done", 32'(done), 0);
      next_cyc();
    end

    // Test 5b: async reset in DRAIN, then a clean test-1 run
    start = 1'b1;
    next_cyc();
    start = 1'b0;
    repeat (7) next_cyc();
    @(negedge clk);
    check("drain_busy", 32'(busy), 1);
    check("drain_mac_en", 32'(mac_en), 0);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_layer_done", 32'(layer_done), 0);
    check("arst_done", 32'(done), 0);
    next_cyc();
    rst = 1'b0;
    next_cyc();
    run_check(-1);

    // Test 6: start during RUN ignored; start+abort in IDLE stays idle
    run_check(4);
    start = 1'b1;
    abort = 1'b1;
    next_cyc();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("sa_busy", 32'(busy), 0);
    next_cyc();
    @(negedge clk);
    check("sa_busy2", 32'(busy), 0);
    check("sa_mac_en", 32'(mac_en), 0);
    next_cyc();

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      cfg_last_layer = LAYER_W'($urandom_range(3));
      for (int i = 0; i < 4; i++) begin
        in_tbl[i]  = CNT_W'($urandom_range(5));
        out_tbl[i] = CNT_W'($urandom_range(4));
      end
      for (int i = 0; i < MAXC; i++) ready[i] = ($urandom_range(3) != 0);
      run_check(($urandom_range(1) != 0) ? int'($urandom_range(1, 30)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
